// File: rtl/calu_sched_pkg.sv
// rtl/calu_sched_pkg.sv - shared core types, latency defaults and branch-mask helpers for calu_sched
package calu_sched_pkg;

  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int CHECKPOINTS       = 4;
  localparam int CHECKPOINTS_LOG   = 2;
  localparam int DEF_MUL_LATENCY   = 3;
  localparam int DEF_DIV_LATENCY   = 8;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  typedef logic [SIZE_PHYSICAL_LOG-1:0] ptag_t;
  typedef logic [CHECKPOINTS-1:0]       bmask_t;
  typedef logic [CHECKPOINTS_LOG-1:0]   cp_id_t;

  typedef struct packed {
    logic   valid;
    ptag_t  tag;
    bmask_t mask;
  } slot_t;

  function automatic logic kill_hit(bmask_t m, logic ver, logic mis, cp_id_t id);
    return ver & mis & m[id];
  endfunction

  // A correctly predicted branch no longer guards anything younger.
  function automatic bmask_t resolve_mask(bmask_t m, logic ver, logic mis, cp_id_t id);
    return (ver & ~mis) ? (m & ~(bmask_t'(1) << id)) : m;
  endfunction

  function automatic slot_t age_slot(slot_t s, logic ver, logic mis, cp_id_t id);
    slot_t r;
    if (kill_hit(s.mask, ver, mis, id)) begin
      r = '0;
    end else begin
      r      = s;
      r.mask = resolve_mask(s.mask, ver, mis, id);
    end
    return r;
  endfunction

endpackage

// File: rtl/calu_sched_if.sv
// rtl/calu_sched_if.sv - request, branch-resolution and tag-broadcast bundle of calu_sched
interface calu_sched_if;
  import calu_sched_pkg::*;

  logic   reqValid_i;
  logic   reqIsDiv_i;
  ptag_t  reqDest_i;
  bmask_t reqMask_i;
  logic   ctrlVerified_i;
  logic   ctrlMispredict_i;
  cp_id_t ctrlSMTid_i;
  logic   grant_o;
  logic   divBusy_o;
  logic   tagValid_o;
  ptag_t  tag_o;

  modport master (
    output reqValid_i, reqIsDiv_i, reqDest_i, reqMask_i,
    output ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i,
    input  grant_o, divBusy_o, tagValid_o, tag_o
  );

  modport slave (
    input  reqValid_i, reqIsDiv_i, reqDest_i, reqMask_i,
    input  ctrlVerified_i, ctrlMispredict_i, ctrlSMTid_i,
    output grant_o, divBusy_o, tagValid_o, tag_o
  );

endinterface

// File: rtl/calu_sched_div_fsm.sv
// rtl/calu_sched_div_fsm.sv - calu_div_fsm: occupancy FSM of the non-pipelined divider
module calu_div_fsm
  import calu_sched_pkg::*;
#(
  parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   div_grant,
  input  bmask_t grant_mask,
  input  logic   ctrl_verified,
  input  logic   ctrl_mispredict,
  input  cp_id_t ctrl_id,
  output logic   busy
);

  localparam int CNT_W = $clog2(DIV_LATENCY);

  div_state_e state;
  logic [CNT_W-1:0] cnt;
  bmask_t div_mask;

  // Busy spans DIV_LATENCY-1 cycles so the divider frees up in its own broadcast cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DIV_IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      div_mask <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_grant) begin
            state    <= DIV_BUSY;
            busy     <= 1'b1;
            cnt      <= CNT_W'(DIV_LATENCY - 2);
            div_mask <= grant_mask;
          end
        end
        DIV_BUSY: begin
          if (kill_hit(div_mask, ctrl_verified, ctrl_mispredict, ctrl_id) || cnt == '0) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt      <= cnt - 1'b1;
            div_mask <= resolve_mask(div_mask, ctrl_verified, ctrl_mispredict, ctrl_id);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/calu_sched.sv
// rtl/calu_sched.sv - complex-ALU issue scheduler sharing one wakeup-tag port between mul and div
// Optional divider scheduling is enabled by defining CALU_DIV_EN.
module calu_sched
  import calu_sched_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
  input logic         clk,
  input logic         reset,
  calu_sched_if.slave bus
);

`ifdef CALU_DIV_EN
  localparam int DEPTH = DIV_LATENCY;
`else
  localparam int DEPTH = MUL_LATENCY;
`endif
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // slots[k] holds the entry that broadcasts k cycles from now.
  slot_t slots [DEPTH];

  logic             kill_req;
  logic             mul_free;
  logic             div_ok;
  logic             div_busy;
  logic             grant;
  logic             out_live;
  logic [IDX_W-1:0] wr_idx;
  bmask_t           req_mask;

  assign kill_req = kill_hit(bus.reqMask_i, bus.ctrlVerified_i, bus.ctrlMispredict_i, bus.ctrlSMTid_i);
  assign req_mask = resolve_mask(bus.reqMask_i, bus.ctrlVerified_i, bus.ctrlMispredict_i, bus.ctrlSMTid_i);

`ifdef CALU_DIV_EN
  // A divide's slot lies one past the pipeline end, so only the divider FSM gates it.
  assign mul_free = ~slots[MUL_LATENCY].valid;
  assign div_ok   = ~div_busy;
  assign wr_idx   = bus.reqIsDiv_i ? IDX_W'(DIV_LATENCY - 1) : IDX_W'(MUL_LATENCY - 1);

  calu_div_fsm #(
    .DIV_LATENCY (DIV_LATENCY)
  ) u_div_fsm (
    .clk             (clk),
    .reset           (reset),
    .div_grant       (grant & bus.reqIsDiv_i),
    .grant_mask      (req_mask),
    .ctrl_verified   (bus.ctrlVerified_i),
    .ctrl_mispredict (bus.ctrlMispredict_i),
    .ctrl_id         (bus.ctrlSMTid_i),
    .busy            (div_busy)
  );
`else
  // With a single latency every grant lands one past the youngest entry: never contended.
  assign mul_free = 1'b1;
  assign div_ok   = 1'b0;
  assign div_busy = 1'b0;
  assign wr_idx   = IDX_W'(MUL_LATENCY - 1);
`endif

  assign grant = ~reset & bus.reqValid_i & ~kill_req & (bus.reqIsDiv_i ? div_ok : mul_free);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slots[i] <= age_slot(slots[i+1], bus.ctrlVerified_i, bus.ctrlMispredict_i, bus.ctrlSMTid_i);
      end
      slots[DEPTH-1] <= '0;
      if (grant) slots[wr_idx] <= '{valid: 1'b1, tag: bus.reqDest_i, mask: req_mask};
    end
  end

  assign out_live = ~reset & slots[0].valid
                  & ~kill_hit(slots[0].mask, bus.ctrlVerified_i, bus.ctrlMispredict_i, bus.ctrlSMTid_i);

  assign bus.grant_o    = grant;
  assign bus.divBusy_o  = ~reset & div_busy;
  assign bus.tagValid_o = out_live;
  assign bus.tag_o      = out_live ? slots[0].tag : '0;

endmodule
